// File: rtl/dino_game_pkg.sv
// -----------------------------------------------------------------------------
// dino_game_pkg
//  Shared types and geometry for the VGA dino game. The renderer uses the same
//  geometry constants, so they are kept here and nowhere else.
//  Contents:
//   - game_state_e : top-level game state (IDLE / RUN / OVER)
//   - jump_state_e : dino jump phase (GROUNDED / RISE / FALL)
//   - sprite geometry, jump trajectory, cactus scroll and score constants
// -----------------------------------------------------------------------------
package dino_game_pkg;

   // Screen geometry shared with the renderer
   localparam int unsigned GROUND_Y      = 335;
   localparam int unsigned DINO_H        = 60;
   localparam int unsigned CACTI_START_X = 550;

   // Jump trajectory
   localparam int unsigned JUMP_HEIGHT   = 100;
   localparam int unsigned JUMP_STEP     = 4;
   localparam int unsigned REST_Y        = GROUND_Y - DINO_H;      // 275
   localparam int unsigned APEX_Y        = REST_Y - JUMP_HEIGHT;   // 175

   // Cactus scroll
   localparam int unsigned CACTI_WRAP_X  = 10;
   localparam logic [3:0]  SPEED_INIT    = 4'd1;
   localparam int unsigned SPEED_MAX     = 8;

   // Score
   localparam int unsigned SCORE_DIV     = 6;
   localparam int unsigned SCORE_MAX     = 9999;
   localparam int unsigned SPEEDUP_EVERY = 100;
   localparam int unsigned FRAME_CNT_W   = $clog2(SCORE_DIV);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_OVER = 2'd2
   } game_state_e;

   typedef enum logic [1:0] {
      JMP_GROUNDED = 2'd0,
      JMP_RISE     = 2'd1,
      JMP_FALL     = 2'd2
   } jump_state_e;

endpackage

// File: rtl/dino_jump_fsm.sv
// -----------------------------------------------------------------------------
// dino_jump_fsm
//  Dino jump trajectory: GROUNDED -> RISE -> FALL -> GROUNDED, moving the dino
//  JUMP_STEP rows per advancing frame and clamping at the apex and rest rows.
//  Ports:
//   clk, reset  clock; asynchronous active-high reset
//   tick        frame pulse
//   enable      trajectory may advance on this tick (game running, no collision)
//   jump_req    a jump press was latched since the last tick
//   clear       synchronous return to rest (game going back to IDLE)
//   dino_y      dino sprite top row
// -----------------------------------------------------------------------------
module dino_jump_fsm
   import dino_game_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        tick,
   input  logic        enable,
   input  logic        jump_req,
   input  logic        clear,
   output logic [31:0] dino_y
);

   jump_state_e jstate_q, jstate_d;
   logic [31:0] dino_y_q, dino_y_d;
   logic [31:0] rise_y, fall_y;

   // NOTE: every variable written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      rise_y   = (dino_y_q <= APEX_Y + JUMP_STEP) ? 32'(APEX_Y) : dino_y_q - JUMP_STEP;
      fall_y   = (dino_y_q + JUMP_STEP >= REST_Y) ? 32'(REST_Y) : dino_y_q + JUMP_STEP;
      jstate_d = jstate_q;
      dino_y_d = dino_y_q;
      if (clear) begin
         jstate_d = JMP_GROUNDED;
         dino_y_d = 32'(REST_Y);
      end else if (tick && enable) begin
         unique case (jstate_q)
            JMP_GROUNDED: begin
               if (jump_req) begin
                  // The launch tick already moves the dino up one step.
                  dino_y_d = rise_y;
                  jstate_d = (rise_y <= APEX_Y) ? JMP_FALL : JMP_RISE;
               end
            end
            JMP_RISE: begin
               dino_y_d = rise_y;
               if (rise_y <= APEX_Y) jstate_d = JMP_FALL;
            end
            JMP_FALL: begin
               dino_y_d = fall_y;
               if (fall_y >= REST_Y) jstate_d = JMP_GROUNDED;
            end
            default: jstate_d = JMP_GROUNDED;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops sample
   // the pre-edge values, independent of process ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         jstate_q <= JMP_GROUNDED;
         dino_y_q <= 32'(REST_Y);
      end else begin
         jstate_q <= jstate_d;
         dino_y_q <= dino_y_d;
      end
   end

   assign dino_y = dino_y_q;

endmodule

// File: rtl/dino_game_sequencer.sv
// -----------------------------------------------------------------------------
// dino_game_sequencer
//  Game-level controller for the VGA dino game: IDLE/RUN/OVER state machine,
//  button synchronizer and press detector, cactus scroll, score, and the jump
//  trajectory sub-module. All game state advances on frame_tick while running.
//  Configuration macro: SCORE_SPEEDUP_EN -- when defined, cactus speed rises by
//  one (up to 8) whenever the score increments onto a multiple of 100; when
//  undefined, speed is a constant 1.
//  Ports:
//   clk, reset  clock; asynchronous active-high reset
//   frame_tick  one-clk pulse per frame
//   btn_up      raw asynchronous jump/start button
//   collision   sprite overlap level from the renderer
//   game_on     registered: state is RUN
//   game_over   registered: state is OVER
//   dino_y      dino top row
//   cacti_x     cactus left column
//   score       frames-survived score (binary, saturating)
//   speed       cactus pixels per frame
// -----------------------------------------------------------------------------
module dino_game_sequencer
   import dino_game_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_tick,
   input  logic        btn_up,
   input  logic        collision,
   output logic        game_on,
   output logic        game_over,
   output logic [31:0] dino_y,
   output logic [31:0] cacti_x,
   output logic [13:0] score,
   output logic [3:0]  speed
);

   localparam logic [FRAME_CNT_W-1:0] FRAME_LAST = FRAME_CNT_W'(SCORE_DIV - 1);

   game_state_e state_q, state_d;
   logic btn_sync1_q, btn_sync1_d, btn_sync2_q, btn_sync2_d;
   logic btn_prev_q, btn_prev_d, press_q, press_d;
   logic game_on_q, game_on_d, game_over_q, game_over_d;
   logic jump_latch_q, jump_latch_d;
   logic [31:0] cacti_x_q, cacti_x_d;
   logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [13:0] score_q, score_d;
   logic run_live, run_step, jump_press, start_run, back_to_idle, score_inc;

   // Two-flop synchronizer on the async button, then a registered rising-edge
   // detect: press_q is a one-clk pulse three clocks after btn_up rises.
   always_comb begin
      btn_sync1_d = btn_up;
      btn_sync2_d = btn_sync1_q;
      btn_prev_d  = btn_sync2_q;
      press_d     = btn_sync2_q && !btn_prev_q;
   end

   // Top FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (press_q)   state_d = ST_RUN;
         ST_RUN:  if (collision) state_d = ST_OVER;
         ST_OVER: if (press_q)   state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Top FSM: outputs and control strobes. A collision blocks every update in
   // the same clk, including a coincident tick or press.
   always_comb begin
      game_on_d    = (state_q == ST_RUN);
      game_over_d  = (state_q == ST_OVER);
      run_live     = (state_q == ST_RUN) && !collision;
      run_step     = run_live && frame_tick;
      jump_press   = run_live && press_q;
      start_run    = (state_q == ST_IDLE) && press_q;
      back_to_idle = (state_q == ST_OVER) && press_q;
      score_inc    = run_step && (frame_cnt_q == FRAME_LAST) && (score_q != 14'(SCORE_MAX));
   end

   // Cactus, score and jump-request latch
   always_comb begin
      cacti_x_d    = cacti_x_q;
      frame_cnt_d  = frame_cnt_q;
      score_d      = score_q;
      // The latch only covers the interval between two ticks.
      jump_latch_d = (frame_tick || back_to_idle) ? 1'b0 : (jump_latch_q || jump_press);

      if (back_to_idle) begin
         cacti_x_d   = 32'(CACTI_START_X);
         frame_cnt_d = '0;
      end else if (start_run) begin
         frame_cnt_d = '0;
         score_d     = '0;
      end else if (run_step) begin
         // Wrap test happens before the subtract, so cacti_x never underflows.
         if (cacti_x_q < CACTI_WRAP_X + 32'(speed)) cacti_x_d = 32'(CACTI_START_X);
         else                                       cacti_x_d = cacti_x_q - 32'(speed);
         frame_cnt_d = (frame_cnt_q == FRAME_LAST) ? '0 : frame_cnt_q + 1'b1;
         if (score_inc) score_d = score_q + 14'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         btn_sync1_q  <= 1'b0;
         btn_sync2_q  <= 1'b0;
         btn_prev_q   <= 1'b0;
         press_q      <= 1'b0;
         game_on_q    <= 1'b0;
         game_over_q  <= 1'b0;
         jump_latch_q <= 1'b0;
         cacti_x_q    <= 32'(CACTI_START_X);
         frame_cnt_q  <= '0;
         score_q      <= '0;
      end else begin
         state_q      <= state_d;
         btn_sync1_q  <= btn_sync1_d;
         btn_sync2_q  <= btn_sync2_d;
         btn_prev_q   <= btn_prev_d;
         press_q      <= press_d;
         game_on_q    <= game_on_d;
         game_over_q  <= game_over_d;
         jump_latch_q <= jump_latch_d;
         cacti_x_q    <= cacti_x_d;
         frame_cnt_q  <= frame_cnt_d;
         score_q      <= score_d;
      end
   end

`ifdef SCORE_SPEEDUP_EN
   logic [3:0] speed_q, speed_d;
   logic [13:0] score_next;

   // Speed changes land with the score update, so the new speed is first used
   // for the cactus on the following tick.
   always_comb begin
      score_next = score_q + 14'd1;
      speed_d    = speed_q;
      if (back_to_idle || start_run) begin
         speed_d = SPEED_INIT;
      end else if (score_inc && (score_next % 14'(SPEEDUP_EVERY) == 14'd0) &&
                   (speed_q != 4'(SPEED_MAX))) begin
         speed_d = speed_q + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) speed_q <= SPEED_INIT;
      else       speed_q <= speed_d;
   end

   assign speed = speed_q;
`else
   assign speed = SPEED_INIT;
`endif

   dino_jump_fsm u_jump (
      .clk      (clk),
      .reset    (reset),
      .tick     (frame_tick),
      .enable   (run_live),
      .jump_req (jump_latch_q),
      .clear    (back_to_idle),
      .dino_y   (dino_y)
   );

   assign game_on   = game_on_q;
   assign game_over = game_over_q;
   assign cacti_x   = cacti_x_q;
   assign score     = score_q;

endmodule
